// File: rtl/sipo_rr_sched_if.sv
// Bundle of request, serial-steering, sipo and output handshake signals for sipo_rr_sched.
// Latency: none; wires only.
// Backpressure: out_ready (master -> slave) stalls the scheduler in its output state.
interface sipo_rr_sched_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
);
    localparam int CH_W = $clog2(NREQ);

    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  ser_in;
    logic [NREQ-1:0]  gnt;
    logic             sipo_shift_en;
    logic             sipo_serial_in;
    logic [WIDTH-1:0] sipo_par_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CH_W-1:0]  out_ch;
    logic             busy;

    // Scheduler side
    modport slave (
        input  req, ser_in, sipo_par_in, out_ready,
        output gnt, sipo_shift_en, sipo_serial_in, out_valid, out_data, out_ch, busy
    );

    // Environment side: sources, sipo and downstream consumer
    modport master (
        output req, ser_in, sipo_par_in, out_ready,
        input  gnt, sipo_shift_en, sipo_serial_in, out_valid, out_data, out_ch, busy
    );
endinterface

// File: rtl/sipo_rr_sched.sv
// Round-robin scheduler steering one of NREQ serial sources into a shared sipo per frame.
// Latency: req seen in IDLE at t -> WIDTH shift cycles -> out_valid at t+WIDTH+1.
// Backpressure: holds out_valid/out_data/out_ch stable until out_ready; nothing shifts meanwhile.
// Optional macro SIPO_SCHED_B2B_EN: re-arbitrate on the output handshake and skip IDLE.
module sipo_rr_sched #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    sipo_rr_sched_if.slave  bus
);
    localparam int CH_W  = $clog2(NREQ);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t           r_state;
    logic [CH_W-1:0]  r_rr_ptr;
    logic [CH_W-1:0]  r_cur_ch;
    logic [CH_W-1:0]  r_out_ch;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [NREQ-1:0]  r_gnt;
    logic             r_shift_en;
    logic             r_out_valid;
    logic             r_busy;

    logic [CH_W-1:0]  w_next_ptr;
    logic [CH_W-1:0]  w_search_ptr;
    logic [CH_W-1:0]  w_pick;
    logic             w_any_req;

    // First requester at or after ptr, searching cyclically; returns ptr when none is set.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NREQ-1:0] reqs,
                                                 input logic [CH_W-1:0] ptr);
        logic [CH_W-1:0] sel;
        logic [CH_W-1:0] cand;
        logic            found;
        sel   = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && reqs[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
            cand = (cand == CH_W'(NREQ - 1)) ? '0 : cand + 1'b1;
        end
        return sel;
    endfunction

    // Channel after the current one, wrapping at NREQ-1; used as the next search start.
    assign w_next_ptr   = (r_cur_ch == CH_W'(NREQ - 1)) ? '0 : r_cur_ch + 1'b1;
    // In VALID the search must start past the channel just served, so use the pointer's next value.
    assign w_search_ptr = (r_state == S_VALID) ? w_next_ptr : r_rr_ptr;
    assign w_pick       = rr_pick(bus.req, w_search_ptr);
    assign w_any_req    = |bus.req;

    // Scheduler FSM with registered grant, shift enable, output valid/channel and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_cur_ch    <= '0;
            r_out_ch    <= '0;
            r_bit_cnt   <= '0;
            r_gnt       <= '0;
            r_shift_en  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_cur_ch   <= w_pick;
                        r_bit_cnt  <= '0;
                        r_gnt      <= NREQ'(1) << w_pick;
                        r_shift_en <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Frame always runs to WIDTH bits; req is not looked at here.
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (r_bit_cnt == CNT_W'(WIDTH - 1)) begin
                        r_bit_cnt   <= '0;
                        r_gnt       <= '0;
                        r_shift_en  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_ch    <= r_cur_ch;
                        r_state     <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (bus.out_ready) begin
                        r_rr_ptr    <= w_next_ptr;
                        r_out_valid <= 1'b0;
                        r_out_ch    <= '0;
`ifdef SIPO_SCHED_B2B_EN
                        if (w_any_req) begin
                            r_cur_ch   <= w_pick;
                            r_bit_cnt  <= '0;
                            r_gnt      <= NREQ'(1) << w_pick;
                            r_shift_en <= 1'b1;
                            r_state    <= S_SHIFT;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
`else
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
`endif
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_gnt      <= '0;
                    r_shift_en <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt            = r_gnt;
    assign bus.sipo_shift_en  = r_shift_en;
    // Serial path is combinational so the granted source's bit lands in the sipo the same cycle.
    assign bus.sipo_serial_in = r_shift_en ? bus.ser_in[r_cur_ch] : 1'b0;
    assign bus.out_valid      = r_out_valid;
    // The sipo holds while shift_en is low, so its parallel output is stable throughout VALID.
    assign bus.out_data       = r_out_valid ? bus.sipo_par_in : '0;
    assign bus.out_ch         = r_out_ch;
    assign bus.busy           = r_busy;
endmodule

// File: tb/tb_sipo_rr_sched.sv
// Directed bench for sipo_rr_sched: WIDTH=4/NREQ=4 and WIDTH=8/NREQ=3 instances, each with a sipo.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: out_ready driven per scenario.
module tb_sipo_rr_sched;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sipo_rr_sched_if #(.WIDTH(4), .NREQ(4)) u_a ();
    sipo_rr_sched_if #(.WIDTH(8), .NREQ(3)) u_b ();

    sipo_rr_sched #(.WIDTH(4), .NREQ(4)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(u_a));
    sipo_rr_sched #(.WIDTH(8), .NREQ(3)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(u_b));

    logic [3:0] r_sipo_a;
    logic [7:0] r_sipo_b;

    // Attached sipo deserializers, sharing rst_n with the scheduler; shift in at the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sipo_a <= '0;
            r_sipo_b <= '0;
        end else begin
            if (u_a.sipo_shift_en) r_sipo_a <= {r_sipo_a[2:0], u_a.sipo_serial_in};
            if (u_b.sipo_shift_en) r_sipo_b <= {r_sipo_b[6:0], u_b.sipo_serial_in};
        end
    end
    assign u_a.sipo_par_in = r_sipo_a;
    assign u_b.sipo_par_in = r_sipo_b;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++;
        if ({u_a.gnt, u_a.sipo_shift_en, u_a.sipo_serial_in, u_a.out_valid, u_a.out_data,
             u_a.out_ch, u_a.busy} !== 14'b0) begin
            bad++;
            $display("FAIL reset_a_outputs: got gnt=%b sh=%b si=%b v=%b d=%b ch=%0d busy=%b want all 0",
                     u_a.gnt, u_a.sipo_shift_en, u_a.sipo_serial_in, u_a.out_valid, u_a.out_data,
                     u_a.out_ch, u_a.busy);
        end
        total++;
        if ({u_b.gnt, u_b.sipo_shift_en, u_b.out_valid, u_b.out_data, u_b.out_ch, u_b.busy} !== 16'b0) begin
            bad++;
            $display("FAIL reset_b_outputs: got gnt=%b v=%b d=%h busy=%b want all 0",
                     u_b.gnt, u_b.out_valid, u_b.out_data, u_b.busy);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if ({u_a.busy, u_a.gnt} !== 5'b0) begin
            bad++;
            $display("FAIL idle_no_req: got busy=%b gnt=%b want 0/0000", u_a.busy, u_a.gnt);
        end
    endtask

    // Single frame on ch2 (1,0,1,1), req dropped mid-frame, then 5+ stall cycles in VALID.
    task automatic test_single_frame();
        logic [3:0] bits;
        logic       b;
        bits = 4'b1011;
        u_a.req = 4'b0100;
        u_a.ser_in = 4'b0000;
        u_a.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if ({u_a.gnt, u_a.sipo_shift_en, u_a.out_valid, u_a.busy} !== 7'b0100_1_0_1) begin
                bad++;
                $display("FAIL single_shift_ctl[%0d]: got gnt=%b sh=%b v=%b busy=%b want 0100/1/0/1",
                         k, u_a.gnt, u_a.sipo_shift_en, u_a.out_valid, u_a.busy);
            end
            b = bits[3-k];
            u_a.ser_in = b ? 4'b0100 : 4'b1011;
            if (k == 1) u_a.req = 4'b0000;
            #1;
            total++;
            if (u_a.sipo_serial_in !== b) begin
                bad++;
                $display("FAIL single_serial_in[%0d]: got %b want %b", k, u_a.sipo_serial_in, b);
            end
        end
        for (int s = 0; s < 6; s++) begin
            tick();
            total++;
            if ({u_a.out_valid, u_a.out_data, u_a.out_ch, u_a.gnt, u_a.sipo_shift_en, u_a.busy}
                !== {1'b1, 4'b1011, 2'd2, 4'b0000, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL single_valid_hold[%0d]: got v=%b d=%b ch=%0d gnt=%b sh=%b busy=%b want 1/1011/2/0000/0/1",
                         s, u_a.out_valid, u_a.out_data, u_a.out_ch, u_a.gnt, u_a.sipo_shift_en, u_a.busy);
            end
            u_a.ser_in = 4'(s * 5 + 3);
            if (s == 5) u_a.out_ready = 1'b1;
        end
        tick();
        total++;
        if ({u_a.out_valid, u_a.out_data, u_a.out_ch, u_a.gnt, u_a.busy} !== 12'b0) begin
            bad++;
            $display("FAIL single_back_idle: got v=%b d=%b ch=%0d gnt=%b busy=%b want all 0",
                     u_a.out_valid, u_a.out_data, u_a.out_ch, u_a.gnt, u_a.busy);
        end
        u_a.out_ready = 1'b0;
        u_a.ser_in = 4'b0000;
    endtask

    // All four requesting: channels served 0,1,2,3,0 with each line carrying its own pattern.
    task automatic test_rr_fair();
        logic [3:0] pat [4];
        logic [3:0] eg;
        int         ch;
        pat = '{4'b1001, 4'b0110, 4'b1100, 4'b0011};
        do_reset();
        u_a.req = 4'b1111;
        u_a.out_ready = 1'b1;
        u_a.ser_in = 4'b0000;
        for (int f = 0; f < 5; f++) begin
            ch = f % 4;
            eg = 4'b0001 << ch;
            for (int k = 0; k < 4; k++) begin
                tick();
                total++;
                if ({u_a.gnt, u_a.sipo_shift_en} !== {eg, 1'b1}) begin
                    bad++;
                    $display("FAIL rr_gnt f%0d k%0d: got gnt=%b sh=%b want %b/1", f, k,
                             u_a.gnt, u_a.sipo_shift_en, eg);
                end
                for (int i = 0; i < 4; i++) u_a.ser_in[i] = pat[i][3-k];
            end
            tick();
            total++;
            if ({u_a.out_valid, u_a.out_ch, u_a.out_data} !== {1'b1, 2'(ch), pat[ch]}) begin
                bad++;
                $display("FAIL rr_word f%0d: got v=%b ch=%0d d=%b want 1/%0d/%b", f,
                         u_a.out_valid, u_a.out_ch, u_a.out_data, ch, pat[ch]);
            end
            if (f == 4) u_a.req = 4'b0000;
`ifndef SIPO_SCHED_B2B_EN
            tick();
            total++;
            if ({u_a.busy, u_a.gnt} !== 5'b0) begin
                bad++;
                $display("FAIL rr_idle_gap f%0d: got busy=%b gnt=%b want 0/0000", f, u_a.busy, u_a.gnt);
            end
`endif
        end
        tick();
        total++;
        if (u_a.busy !== 1'b0) begin
            bad++;
            $display("FAIL rr_end_idle: got busy=%b want 0", u_a.busy);
        end
    endtask

    // Reset after two shifts of a ch1 frame; next ch1 frame must carry only the new bits.
    task automatic test_reset_mid_frame();
        logic [3:0] bits;
        logic       b;
        bits = 4'b0101;
        u_a.req = 4'b0010;
        u_a.out_ready = 1'b1;
        tick();
        u_a.ser_in = 4'b0010;
        tick();
        u_a.ser_in = 4'b0010;
        tick();
        total++;
        if (u_a.gnt !== 4'b0010) begin
            bad++;
            $display("FAIL mid_gnt_before_rst: got %b want 0010", u_a.gnt);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({u_a.gnt, u_a.sipo_shift_en, u_a.sipo_serial_in, u_a.out_valid, u_a.out_data,
             u_a.out_ch, u_a.busy} !== 14'b0) begin
            bad++;
            $display("FAIL mid_rst_outputs: got gnt=%b sh=%b si=%b v=%b d=%b busy=%b want all 0",
                     u_a.gnt, u_a.sipo_shift_en, u_a.sipo_serial_in, u_a.out_valid, u_a.out_data, u_a.busy);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            b = bits[3-k];
            u_a.ser_in = {2'b00, b, 1'b1};
        end
        tick();
        total++;
        if ({u_a.out_valid, u_a.out_ch, u_a.out_data} !== {1'b1, 2'd1, 4'b0101}) begin
            bad++;
            $display("FAIL mid_next_frame: got v=%b ch=%0d d=%b want 1/1/0101",
                     u_a.out_valid, u_a.out_ch, u_a.out_data);
        end
        u_a.req = 4'b0000;
        u_a.ser_in = 4'b0000;
        tick();
        tick();
    endtask

    // Two requesters held: frame period and idle cycles between frames.
    task automatic test_throughput();
        int cyc;
        int last;
        int nframes;
        int idle;
        int exp_period;
        int exp_idle;
`ifdef SIPO_SCHED_B2B_EN
        exp_period = 5;
        exp_idle   = 0;
`else
        exp_period = 6;
        exp_idle   = 3;
`endif
        cyc = 0;
        last = 0;
        nframes = 0;
        idle = 0;
        do_reset();
        u_a.req = 4'b0011;
        u_a.out_ready = 1'b1;
        u_a.ser_in = 4'b0000;
        while (nframes < 4 && cyc < 60) begin
            tick();
            cyc++;
            if (nframes >= 1 && !u_a.busy) idle++;
            if (u_a.out_valid) begin
                if (nframes > 0) begin
                    total++;
                    if (cyc - last !== exp_period) begin
                        bad++;
                        $display("FAIL tput_period[%0d]: got %0d cycles want %0d", nframes, cyc - last, exp_period);
                    end
                end
                total++;
                if (u_a.out_ch !== 2'(nframes % 2)) begin
                    bad++;
                    $display("FAIL tput_ch[%0d]: got %0d want %0d", nframes, u_a.out_ch, nframes % 2);
                end
                last = cyc;
                nframes++;
            end
        end
        total++;
        if (nframes !== 4) begin
            bad++;
            $display("FAIL tput_timeout: got %0d frames want 4", nframes);
        end
        total++;
        if (idle !== exp_idle) begin
            bad++;
            $display("FAIL tput_idle_cycles: got %0d want %0d", idle, exp_idle);
        end
        u_a.req = 4'b0000;
        tick();
        tick();
    endtask

    // WIDTH=8, NREQ=3, req=101: channels 0,2,0,2 with 8 shifts each.
    task automatic test_wide();
        logic [7:0] pb [3];
        logic [2:0] eg;
        int         ch;
        pb = '{8'hA5, 8'hFF, 8'h3C};
        u_b.req = 3'b101;
        u_b.out_ready = 1'b1;
        u_b.ser_in = 3'b000;
        for (int f = 0; f < 4; f++) begin
            ch = (f % 2 == 1) ? 2 : 0;
            eg = 3'b001 << ch;
            for (int k = 0; k < 8; k++) begin
                tick();
                total++;
                if ({u_b.gnt, u_b.sipo_shift_en, u_b.out_valid} !== {eg, 1'b1, 1'b0}) begin
                    bad++;
                    $display("FAIL wide_gnt f%0d k%0d: got gnt=%b sh=%b v=%b want %b/1/0", f, k,
                             u_b.gnt, u_b.sipo_shift_en, u_b.out_valid, eg);
                end
                for (int i = 0; i < 3; i++) u_b.ser_in[i] = pb[i][7-k];
            end
            tick();
            total++;
            if ({u_b.out_valid, u_b.out_ch, u_b.out_data} !== {1'b1, 2'(ch), pb[ch]}) begin
                bad++;
                $display("FAIL wide_word f%0d: got v=%b ch=%0d d=%h want 1/%0d/%h", f,
                         u_b.out_valid, u_b.out_ch, u_b.out_data, ch, pb[ch]);
            end
            if (f == 3) u_b.req = 3'b000;
`ifndef SIPO_SCHED_B2B_EN
            tick();
            total++;
            if (u_b.busy !== 1'b0) begin
                bad++;
                $display("FAIL wide_idle_gap f%0d: got busy=%b want 0", f, u_b.busy);
            end
`endif
        end
        tick();
        total++;
        if (u_b.busy !== 1'b0) begin
            bad++;
            $display("FAIL wide_end_idle: got busy=%b want 0", u_b.busy);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        u_a.req = '0;
        u_a.ser_in = '0;
        u_a.out_ready = 1'b0;
        u_b.req = '0;
        u_b.ser_in = '0;
        u_b.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        test_reset();
        test_single_frame();
        test_rr_fair();
        test_reset_mid_frame();
        test_throughput();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
